// File: rtl/alu_issue_stage_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : alu_issue_stage_if
// Brief   : Instruction, ALU and writeback signals of the ALU issue stage.
// Revision: 1.0
//------------------------------------------------------------------------------
interface alu_issue_stage_if #(
  parameter int WORD_SIZE     = 16,
  parameter int OPCODE_SIZE   = 4,
  parameter int REG_ADDR_SIZE = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [OPCODE_SIZE-1:0]   in_opcode;
  logic [REG_ADDR_SIZE-1:0] in_rd;
  logic [REG_ADDR_SIZE-1:0] in_rs1;
  logic [REG_ADDR_SIZE-1:0] in_rs2;
  logic [WORD_SIZE-1:0]     in_rs1_data;
  logic [WORD_SIZE-1:0]     in_rs2_data;
  logic                     in_use_imm;
  logic [WORD_SIZE-1:0]     in_imm;
  logic [OPCODE_SIZE-1:0]   alu_opcode;
  logic [WORD_SIZE-1:0]     alu_input1;
  logic [WORD_SIZE-1:0]     alu_input2;
  logic                     alu_enable;
  logic [WORD_SIZE-1:0]     alu_out;
  logic                     wb_valid;
  logic                     wb_ready;
  logic [REG_ADDR_SIZE-1:0] wb_rd;
  logic [WORD_SIZE-1:0]     wb_data;

  // slave: the issue stage itself
  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_rs1_data,
           in_rs2_data, in_use_imm, in_imm, alu_out, wb_ready,
    output in_ready, alu_opcode, alu_input1, alu_input2, alu_enable,
           wb_valid, wb_rd, wb_data
  );

  // master: decoder, ALU and register file around the stage
  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_rs1_data,
           in_rs2_data, in_use_imm, in_imm, alu_out, wb_ready,
    input  in_ready, alu_opcode, alu_input1, alu_input2, alu_enable,
           wb_valid, wb_rd, wb_data
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : alu_issue_stage
// Brief   : Two-entry issue/writeback pipeline around a registered ALU with
//           S2 forwarding and S1 hazard stalls.
// Revision: 1.0
//------------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int WORD_SIZE     = 16,
  parameter int OPCODE_SIZE   = 4,
  parameter int REG_ADDR_SIZE = 3
) (
  input  wire logic         clock,
  input  wire logic         reset_n,
  alu_issue_stage_if.slave  bus
);

  logic                     r_s1_valid;
  logic [REG_ADDR_SIZE-1:0] r_s1_rd;
  logic [OPCODE_SIZE-1:0]   r_opcode;
  logic [WORD_SIZE-1:0]     r_input1;
  logic [WORD_SIZE-1:0]     r_input2;
  logic                     r_s2_valid;
  logic [REG_ADDR_SIZE-1:0] r_wb_rd;

  logic                     w_adv1;
  logic                     w_adv2;
  logic                     w_hz1;
  logic                     w_accept;
  logic                     w_retire;
  logic [WORD_SIZE-1:0]     w_op1;
  logic [WORD_SIZE-1:0]     w_op2;

  assign w_adv2   = !r_s2_valid || bus.wb_ready;
  assign w_adv1   = r_s1_valid && w_adv2;
  assign w_retire = r_s2_valid && bus.wb_ready;

  // S1's result is not computed yet, so any match on it stalls instead of forwarding
  assign w_hz1 = r_s1_valid &&
                 ((bus.in_rs1 == r_s1_rd) ||
                  (!bus.in_use_imm && (bus.in_rs2 == r_s1_rd)));

  assign bus.in_ready = (!r_s1_valid || w_adv1) && !w_hz1;
  assign w_accept     = bus.in_valid && bus.in_ready;

  assign w_op1 = (r_s2_valid && (bus.in_rs1 == r_wb_rd)) ? bus.alu_out
                                                         : bus.in_rs1_data;
  assign w_op2 = bus.in_use_imm                              ? bus.in_imm  :
                 (r_s2_valid && (bus.in_rs2 == r_wb_rd))     ? bus.alu_out :
                                                               bus.in_rs2_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_rd    <= '0;
      r_opcode   <= '0;
      r_input1   <= '0;
      r_input2   <= '0;
      r_s2_valid <= 1'b0;
      r_wb_rd    <= '0;
    end else begin
      // ALU operands only move on accept so alu_out stays valid while disabled
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_rd    <= bus.in_rd;
        r_opcode   <= bus.in_opcode;
        r_input1   <= w_op1;
        r_input2   <= w_op2;
      end else if (w_adv1) begin
        r_s1_valid <= 1'b0;
      end

      if (w_adv1) begin
        r_s2_valid <= 1'b1;
        r_wb_rd    <= r_s1_rd;
      end else if (w_retire) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign bus.alu_enable = w_adv1;
  assign bus.alu_opcode = r_opcode;
  assign bus.alu_input1 = r_input1;
  assign bus.alu_input2 = r_input2;
  assign bus.wb_valid   = r_s2_valid;
  assign bus.wb_rd      = r_wb_rd;
  assign bus.wb_data    = bus.alu_out;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_alu_issue_stage
// Brief   : Scoreboard bench for alu_issue_stage with a behavioural ALU.
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_alu_issue_stage;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_BAD = 4'hF;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   last_ret = 0;

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] data;
    int          acc_cyc;
    bit          chk_lat;
    bit          chk_gap;
  } exp_t;
  exp_t sb[$];

  alu_issue_stage_if #(.WORD_SIZE(16), .OPCODE_SIZE(4), .REG_ADDR_SIZE(3)) bif ();

  alu_issue_stage #(.WORD_SIZE(16), .OPCODE_SIZE(4), .REG_ADDR_SIZE(3)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bif.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Registered ALU: captures while enabled, holds otherwise (and on unknown opcodes)
  always @(posedge clock) begin
    if (bif.alu_enable) begin
      case (bif.alu_opcode)
        OP_ADD:  bif.alu_out <= bif.alu_input1 + bif.alu_input2;
        OP_XOR:  bif.alu_out <= bif.alu_input1 ^ bif.alu_input2;
        default: bif.alu_out <= bif.alu_out;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every retire
  always @(negedge clock) begin
    if (reset_n && bif.wb_valid && bif.wb_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_wb", {29'd0, bif.wb_rd}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_rd", {29'd0, bif.wb_rd}, {29'd0, e.rd});
        check("wb_data", {16'd0, bif.wb_data}, {16'd0, e.data});
        if (e.chk_lat) check("latency", cyc - e.acc_cyc, 32'd2);
        if (e.chk_gap) check("retire_gap", cyc - last_ret, 32'd1);
      end
      last_ret = cyc;
    end
  end

  task automatic set_inputs(input logic [3:0] op, input logic [2:0] rd, rs1, rs2,
                            input logic [15:0] d1, d2, input logic ui, input logic [15:0] imm);
    bif.in_valid    = 1'b1;
    bif.in_opcode   = op;
    bif.in_rd       = rd;
    bif.in_rs1      = rs1;
    bif.in_rs2      = rs2;
    bif.in_rs1_data = d1;
    bif.in_rs2_data = d2;
    bif.in_use_imm  = ui;
    bif.in_imm      = imm;
  endtask

  // Waits for acceptance (bounded), pushes the expected result, returns stall count
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, rs1, rs2,
                       input logic [15:0] d1, d2, input logic ui, input logic [15:0] imm,
                       input logic [15:0] exp, input bit track, input bit lat, input bit gap,
                       output int stalls);
    exp_t e;
    stalls = 0;
    set_inputs(op, rd, rs1, rs2, d1, d2, ui, imm);
    forever begin
      @(negedge clock);
      if (bif.in_ready) begin
        if (track) begin
          e.rd = rd; e.data = exp; e.acc_cyc = cyc; e.chk_lat = lat; e.chk_gap = gap;
          sb.push_back(e);
        end
        @(posedge clock);
        #1;
        bif.in_valid = 1'b0;
        return;
      end
      stalls++;
      if (stalls > 50) begin
        check("accept_timeout", 32'd0, 32'd1);
        bif.in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic reset_checks();
    check("rst_in_ready",   {31'd0, bif.in_ready},   32'd1);
    check("rst_alu_enable", {31'd0, bif.alu_enable}, 32'd0);
    check("rst_wb_valid",   {31'd0, bif.wb_valid},   32'd0);
    check("rst_alu_opcode", {28'd0, bif.alu_opcode}, 32'd0);
    check("rst_alu_input1", {16'd0, bif.alu_input1}, 32'd0);
    check("rst_alu_input2", {16'd0, bif.alu_input2}, 32'd0);
    check("rst_wb_rd",      {29'd0, bif.wb_rd},      32'd0);
  endtask

  task automatic drain();
    repeat (4) @(posedge clock);
    #1;
  endtask

  initial begin
    int st;
    int guard;
    bif.wb_ready = 1'b1;
    set_inputs(4'd0, 3'd0, 3'd0, 3'd0, 16'd0, 16'd0, 1'b0, 16'd0);
    bif.in_valid = 1'b0;

    // Reset asserted mid-cycle takes effect immediately
    #3 reset_n = 1'b0;
    #1 reset_checks();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Independent back-to-back ops, no bubble
    issue(OP_ADD, 3'd1, 3'd2, 3'd3, 16'd3, 16'd4, 1'b0, 16'd0, 16'd7, 1, 1, 0, st);
    issue(OP_XOR, 3'd2, 3'd4, 3'd5, 16'h00F0, 16'h0FF0, 1'b0, 16'd0, 16'h0F00, 1, 1, 1, st);
    check("indep_stalls", st, 32'd0);
    drain();

    // Dependent op: one-cycle stall, then forwarding from S2
    issue(OP_ADD, 3'd1, 3'd2, 3'd3, 16'd5, 16'd6, 1'b0, 16'd0, 16'd11, 1, 1, 0, st);
    issue(OP_ADD, 3'd2, 3'd1, 3'd0, 16'd0, 16'd0, 1'b1, 16'd1, 16'd12, 1, 1, 0, st);
    check("dep_stalls", st, 32'd1);
    drain();

    // Immediate op whose ignored rs2 matches S1's rd does not stall
    issue(OP_ADD, 3'd6, 3'd0, 3'd0, 16'd1, 16'd1, 1'b0, 16'd0, 16'd2, 1, 1, 0, st);
    issue(OP_ADD, 3'd3, 3'd3, 3'd6, 16'd10, 16'hDEAD, 1'b1, 16'd5, 16'd15, 1, 1, 1, st);
    check("imm_stalls", st, 32'd0);
    drain();

    // Writeback backpressure with three ops queued
    bif.wb_ready = 1'b0;
    issue(OP_ADD, 3'd1, 3'd2, 3'd3, 16'd1, 16'd2, 1'b0, 16'd0, 16'd3, 1, 0, 0, st);
    issue(OP_XOR, 3'd2, 3'd4, 3'd5, 16'hFF00, 16'h0F0F, 1'b0, 16'd0, 16'hF00F, 1, 0, 1, st);
    set_inputs(OP_ADD, 3'd4, 3'd6, 3'd7, 16'd100, 16'd200, 1'b0, 16'd0);
    repeat (4) begin
      @(negedge clock);
      check("hold_wb_data",    {16'd0, bif.wb_data},    32'd3);
      check("hold_wb_rd",      {29'd0, bif.wb_rd},      32'd1);
      check("hold_alu_enable", {31'd0, bif.alu_enable}, 32'd0);
      check("hold_in_ready",   {31'd0, bif.in_ready},   32'd0);
    end
    @(posedge clock);
    #1 bif.wb_ready = 1'b1;
    issue(OP_ADD, 3'd4, 3'd6, 3'd7, 16'd100, 16'd200, 1'b0, 16'd0, 16'd300, 1, 1, 1, st);
    drain();

    // Undecoded opcode still retires, carrying the stale ALU result
    issue(OP_BAD, 3'd5, 3'd0, 3'd0, 16'd9, 16'd9, 1'b0, 16'd0, 16'd300, 1, 1, 0, st);
    drain();

    // Reset with both stages full discards everything
    bif.wb_ready = 1'b0;
    issue(OP_ADD, 3'd1, 3'd2, 3'd3, 16'd7, 16'd7, 1'b0, 16'd0, 16'd0, 0, 0, 0, st);
    issue(OP_ADD, 3'd2, 3'd4, 3'd5, 16'd8, 16'd8, 1'b0, 16'd0, 16'd0, 0, 0, 0, st);
    check("full_wb_valid", {31'd0, bif.wb_valid}, 32'd1);
    #3 reset_n = 1'b0;
    #1 reset_checks();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    bif.wb_ready = 1'b1;
    repeat (4) begin
      @(negedge clock);
      check("post_rst_wb_valid", {31'd0, bif.wb_valid}, 32'd0);
    end

    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(posedge clock);
      guard++;
    end
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
# alu_issue_stage

Issue/writeback stage around the single-cycle registered `alu`. Accepts decoded instructions over a valid/ready handshake and selects operands from register-file data, an immediate, or the in-flight ALU result. Drives `alu_enable`/`opcode`/`input1`/`input2`, then presents the captured `alu_out` to the register-file write port over a second valid/ready handshake. Two-entry pipeline: S1 is the issue register and S2 is the result-pending register. Handles read-after-write hazards by forwarding from S2 and stalling on S1.

## Interface
- `WORD_SIZE`, 16, datapath width; must match `alu`
- `OPCODE_SIZE`, 4, opcode width; encodings come from `parameters.vh`
- `REG_ADDR_SIZE`, 3, register index width
- `clock` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: decoded instruction present
- `in_ready` out 1: instruction accepted at the edge where `in_valid && in_ready`
- `in_opcode` in OPCODE_SIZE: operation
- `in_rd`, `in_rs1`, `in_rs2` in REG_ADDR_SIZE: destination and source indices
- `in_rs1_data`, `in_rs2_data` in WORD_SIZE: register-file read data, valid with `in_valid`
- `in_use_imm` in 1: when 1, operand 2 is `in_imm` and `in_rs2` is ignored
- `in_imm` in WORD_SIZE: immediate, already extended
- `alu_opcode` out OPCODE_SIZE: to `alu.opcode`
- `alu_input1`, `alu_input2` out WORD_SIZE: to `alu.input1`, `alu.input2`
- `alu_enable` out 1: to `alu.alu_enable`
- `alu_out` in WORD_SIZE: from `alu.alu_out`
- `wb_valid` out 1: result present
- `wb_ready` in 1: register file takes the result
- `wb_rd` out REG_ADDR_SIZE: destination index
- `wb_data` out WORD_SIZE: result; combinationally equals `alu_out`

## Operation
**State.**
- S1 holds `s1_valid`, `s1_rd`, and the registered `alu_opcode`, `alu_input1`, `alu_input2`.
- S2 holds `s2_valid` and `wb_rd`.

**Handshake control.**
- `adv2 = !s2_valid || wb_ready`.
- `alu_enable = s1_valid && adv2`.
- `adv1 = alu_enable`.
- Retire: `wb_valid = s2_valid`. The result leaves S2 at the edge where `wb_valid && wb_ready`.

**Hazards and forwarding.**
- `hz1 = s1_valid && (in_rs1 == s1_rd || (!in_use_imm && in_rs2 == s1_rd))`.
- `in_ready = (!s1_valid || adv1) && !hz1`. S1's result does not exist yet, so a match on S1 stalls.
- Operand 1 source:
  - `alu_out` if `s2_valid && in_rs1 == wb_rd`;
  - else `in_rs1_data`.
- Operand 2 source:
  - `in_imm` if `in_use_imm`;
  - else `alu_out` if `s2_valid && in_rs2 == wb_rd`;
  - else `in_rs2_data`.
- S1 match takes priority over S2 forwarding, because it stalls.

**Register updates at each edge.**
- On accept: load S1 with the opcode and selected operands, and set `s1_valid = 1`.
- On `adv1` with no accept: clear `s1_valid`.
- When not accepting: `alu_opcode`, `alu_input1`, `alu_input2` hold their values. They must stay stable while `alu_enable = 0`, because the ALU holds `alu_out` only while disabled.
- On `adv1`: set `s2_valid = 1` and `wb_rd = s1_rd`.
- On retire with no `adv1`: clear `s2_valid`.
- On `adv1` and retire in the same edge: S2 is refilled.

**Reset.**
- All outputs and state go to 0, and in-flight instructions are discarded.
- `alu_out` is not reset by the ALU. `wb_valid = 0` masks it.
- Deasserting reset mid-stream does not replay anything.
- Any `in_opcode` is passed through unchanged. Opcodes the ALU does not decode still produce a `wb_valid`; `wb_data` is then the stale `alu_out`.

## Timing
- Accept at edge E0 → `alu_enable` high in the following cycle → ALU captures at E1 → `wb_valid` high after E1. The earliest retire is at E2, so latency is 2 cycles.
- Throughput is 1 instruction/cycle while `wb_ready = 1` and there are no S1 hazards.
- A dependent back-to-back instruction costs exactly 1 bubble, then takes its operand by forwarding from S2.
- When `wb_ready = 0` with both stages full:
  - `in_ready = 0` and `alu_enable = 0`;
  - `wb_data` and `wb_rd` hold steadily until the edge where the result is taken.
- `in_ready` depends combinationally on `wb_ready`, `in_rs1`, `in_rs2`, `in_use_imm`. `wb_data` depends combinationally on `alu_out`. There are no other combinational input→output paths.

## Test plan
1. Assert `reset_n = 0` mid-cycle → immediately `in_ready = 1`, `alu_enable = 0`, `wb_valid = 0`, and all data outputs are 0.
2. Issue `ADD r1 = 3 + 4` then `XOR r2 = 0x00F0 ^ 0x0FF0` back-to-back, independent, with `wb_ready = 1` → `wb` shows `(r1, 7)` on cycle 2 and `(r2, 0x0F00)` on cycle 3, with no bubble.
3. Issue `ADD r1 = 5 + 6` then `ADD r2 = r1 + 1` from register-file data 0 →
   - `in_ready` is low for 1 cycle;
   - the second op forwards 11 from S2;
   - `wb` shows `(r2, 12)`, not 1.
4. Issue `ADDI r3 = r3(10) + imm 5`, with `in_rs2` equal to S1's rd → no stall, because `in_rs2` is ignored; `wb` shows `(r3, 15)`.
5. Hold `wb_ready = 0` for 4 cycles with 3 ops queued →
   - `wb_data` stays constant;
   - `alu_enable` stays 0 and `in_ready` stays 0;
   - on release, results retire in order at one per cycle.
6. Assert reset while S1 and S2 are both valid → after release, no `wb_valid` appears until a new instruction is accepted.
